cp0_unit: RTL

//  Coprocessor-0 register file for the 5-stage MIPS pipeline; sits directly upstream of the exception controller.

---
 rtl/cp0_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file: SR, Cause, EPC, PRId, plus M-stage interrupt/exception request
// evaluation for the exception controller.
module cp0_unit #(
  parameter logic [31:0] PRID       = 32'h0000_2024,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        EXLSet,
  input  logic        EXLClr,
  output logic [31:0] DOut,
  output logic        InReq,
  output logic [31:0] EPC_O,
  output logic [31:0] HandlerPC
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  // EPC is word aligned, so only the upper 30 bits are stored.
  logic [29:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_val;
  logic [31:0] cause_val;

  assign int_req = (|(ip_q & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCode_M != 5'd0) & ~exl_q;
  assign InReq   = int_req | exc_req;

  assign sr_val    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_val = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
  assign EPC_O     = {epc_q, 2'b00};
  assign HandlerPC = HANDLER_PC;

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (EXLSet) begin
      // Taking an exception flushes the M-stage mtc0 and overrides any eret.
      exl_d      = 1'b1;
      bd_d       = BD_M;
      epc_d      = BD_M ? (PC_M[31:2] - 30'd1) : PC_M[31:2];
      exc_code_d = int_req ? 5'd0 : ExcCode_M;
    end else begin
      if (WE) begin
        if (A2 == AddrSr) begin
          im_d  = DIn[15:10];
          exl_d = DIn[1];
          ie_d  = DIn[0];
        end else if (A2 == AddrEpc) begin
          epc_d = DIn[31:2];
        end
      end
      if (EXLClr) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= '0;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    DOut = 32'h0;
    case (A1)
      AddrSr:    DOut = sr_val;
      AddrCause: DOut = cause_val;
      AddrEpc:   DOut = EPC_O;
      AddrPrid:  DOut = PRID;
      default:   DOut = 32'h0;
    endcase
  end

endmodule
